// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter:
// FSM state encoding, requester identifiers and the default wait limit.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_DM = 1'b1
   } req_id_t;

   localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic    i_req_if,
   input  logic    i_req_dm,
   input  req_id_t i_last,
   output logic    o_valid,
   output req_id_t o_id
);

   always_comb begin
      o_valid = i_req_if | i_req_dm;
      o_id    = REQ_IF;
      if (i_req_if && i_req_dm) begin
         o_id = (i_last == REQ_IF) ? REQ_DM : REQ_IF;
      end else if (i_req_dm) begin
         o_id = REQ_DM;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port,
// one transaction at a time, with a wait-cycle abort and registered outputs.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              timeout_err
);

   localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

   state_t            r_state, w_state_next;
   req_id_t           r_last_grant, w_last_grant_next;
   logic [3:0]        r_wait_cnt, w_wait_cnt_next;
   logic              r_mask, w_mask_next;
   logic              r_if_ack, w_if_ack_next;
   logic              r_dm_ack, w_dm_ack_next;
   logic [DATA_W-1:0] r_if_rdata, w_if_rdata_next;
   logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_next;
   logic              r_mem_en, w_mem_en_next;
   logic              r_mem_we, w_mem_we_next;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
   logic              r_busy, w_busy_next;
   logic              r_timeout_err, w_timeout_err_next;

   logic              w_if_eff, w_dm_eff;
   logic              w_gnt_valid;
   req_id_t           w_gnt_id;
   logic              w_wait_expired;
   logic [DATA_W-1:0] w_cap_data;

   // The requester acked last holds its req one extra cycle; ignore it then.
   assign w_if_eff = if_req & ~(r_mask & (r_last_grant == REQ_IF));
   assign w_dm_eff = dm_req & ~(r_mask & (r_last_grant == REQ_DM));

   rr_pick2 u_pick (
      .i_req_if (w_if_eff),
      .i_req_dm (w_dm_eff),
      .i_last   (r_last_grant),
      .o_valid  (w_gnt_valid),
      .o_id     (w_gnt_id)
   );

   assign w_wait_expired = (r_state == ST_WAIT) && (r_wait_cnt == WAIT_LAST);
   assign w_cap_data     = mem_ready ? mem_rdata : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_last_grant  <= REQ_DM;
         r_wait_cnt    <= 4'd0;
         r_mask        <= 1'b0;
         r_if_ack      <= 1'b0;
         r_dm_ack      <= 1'b0;
         r_if_rdata    <= '0;
         r_dm_rdata    <= '0;
         r_mem_en      <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_last_grant  <= w_last_grant_next;
         r_wait_cnt    <= w_wait_cnt_next;
         r_mask        <= w_mask_next;
         r_if_ack      <= w_if_ack_next;
         r_dm_ack      <= w_dm_ack_next;
         r_if_rdata    <= w_if_rdata_next;
         r_dm_rdata    <= w_dm_rdata_next;
         r_mem_en      <= w_mem_en_next;
         r_mem_we      <= w_mem_we_next;
         r_mem_addr    <= w_mem_addr_next;
         r_mem_wdata   <= w_mem_wdata_next;
         r_busy        <= w_busy_next;
         r_timeout_err <= w_timeout_err_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_gnt_valid) w_state_next = ST_ISSUE;
         ST_ISSUE: w_state_next = mem_ready ? ST_RESP : ST_WAIT;
         ST_WAIT:  if (mem_ready || w_wait_expired) w_state_next = ST_RESP;
         ST_RESP:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Computes the next value of every registered output from the transition.
   always_comb begin
      w_last_grant_next  = r_last_grant;
      w_mem_we_next      = r_mem_we;
      w_mem_addr_next    = r_mem_addr;
      w_mem_wdata_next   = r_mem_wdata;
      w_if_rdata_next    = r_if_rdata;
      w_dm_rdata_next    = r_dm_rdata;
      w_timeout_err_next = r_timeout_err;
      w_if_ack_next      = 1'b0;
      w_dm_ack_next      = 1'b0;
      w_mem_en_next      = (w_state_next == ST_ISSUE);
      w_busy_next        = (w_state_next != ST_IDLE);
      w_mask_next        = (r_state == ST_RESP);
      w_wait_cnt_next    = (r_state == ST_WAIT) ? r_wait_cnt + 4'd1 : 4'd0;

      if ((r_state == ST_IDLE) && w_gnt_valid) begin
         w_last_grant_next = w_gnt_id;
         if (w_gnt_id == REQ_DM) begin
            w_mem_we_next    = dm_we;
            w_mem_addr_next  = dm_addr;
            w_mem_wdata_next = dm_wdata;
         end else begin
            w_mem_we_next    = 1'b0;
            w_mem_addr_next  = if_addr;
            w_mem_wdata_next = '0;
         end
      end

      if (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && (w_state_next == ST_RESP)) begin
         if (!mem_ready) w_timeout_err_next = 1'b1;
         if (r_last_grant == REQ_DM) begin
            w_dm_ack_next   = 1'b1;
            w_dm_rdata_next = w_cap_data;
         end else begin
            w_if_ack_next   = 1'b1;
            w_if_rdata_next = w_cap_data;
         end
      end
   end

   assign if_ack      = r_if_ack;
   assign dm_ack      = r_dm_ack;
   assign if_rdata    = r_if_rdata;
   assign dm_rdata    = r_dm_rdata;
   assign mem_en      = r_mem_en;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign busy        = r_busy;
   assign timeout_err = r_timeout_err;

endmodule
